// File: rtl/clock_reset_controller.sv
// Control-side sequencer for the clock & reset manager: divider changes, auto clock gating,
// software reset pulses and a watchdog. Runs only on the always-on reference clock.
module clock_reset_controller #(
   parameter int unsigned RST_PULSE_CYCLES  = 32,
   parameter int unsigned IDLE_GATE_CYCLES  = 64,
   parameter int unsigned DIV_SETTLE_CYCLES = 16,
   parameter int unsigned WDT_WIDTH         = 16
) (
   input  logic                 clk_ref,
   input  logic                 por_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_type,
   input  logic [WDT_WIDTH-1:0] req_data,
   input  logic                 wdt_en,
   input  logic [WDT_WIDTH-1:0] wdt_load,
   input  logic                 cpu_idle,
   input  logic                 wake_req,
   input  logic                 rst_done,
   output logic [2:0]           clk_div_sel,
   output logic                 clk_gate_en,
   output logic                 rst_ext_n,
   output logic                 busy,
   output logic                 wdt_expired,
   output logic                 div_err
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_DIV_GATE   = 3'd1;
   localparam logic [2:0] S_DIV_SWITCH = 3'd2;
   localparam logic [2:0] S_DIV_SETTLE = 3'd3;
   localparam logic [2:0] S_RST_PULSE  = 3'd4;
   localparam logic [2:0] S_RST_WAIT   = 3'd5;

   localparam int unsigned DIV_GATE_CYCLES = 2;
   localparam int unsigned CNT_MAX = (RST_PULSE_CYCLES > DIV_SETTLE_CYCLES) ?
                                     RST_PULSE_CYCLES : DIV_SETTLE_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned IDLE_W  = $clog2(IDLE_GATE_CYCLES + 1);

   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           code_q, code_d;
   logic [2:0]           clk_div_sel_q, clk_div_sel_d;
   logic                 clk_gate_en_q, clk_gate_en_d;
   logic                 rst_ext_n_q, rst_ext_n_d;
   logic                 busy_q, busy_d;
   logic                 wdt_expired_q, wdt_expired_d;
   logic                 div_err_q, div_err_d;
   logic                 req_ready_q, req_ready_d;
   logic                 auto_en_q, auto_en_d;
   logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
   logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
   logic                 wdt_fire;
   logic                 accept;
   logic                 unused_req_bits;

   // Only the low payload bits carry meaning for any request type.
   assign unused_req_bits = ^req_data[WDT_WIDTH-1:3];

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      code_d        = code_q;
      clk_div_sel_d = clk_div_sel_q;
      wdt_expired_d = wdt_expired_q;
      div_err_d     = 1'b0;
      auto_en_d     = auto_en_q;
      wdt_d         = wdt_q;
      idle_cnt_d    = '0;
      clk_gate_en_d = 1'b0;
      rst_ext_n_d   = 1'b1;
      busy_d        = 1'b0;
      req_ready_d   = 1'b0;

      // Expiry preempts any request; req_ready was already withheld for this cycle.
      wdt_fire = (state_q == S_IDLE) && wdt_en && (wdt_q == '0);
      accept   = req_valid && req_ready_q && !wdt_fire;

      case (state_q)
         S_IDLE: begin
            if (cpu_idle && !wake_req) begin
               if (idle_cnt_q != IDLE_W'(IDLE_GATE_CYCLES)) idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               else                                         idle_cnt_d = idle_cnt_q;
            end
            if (!wdt_en)             wdt_d = wdt_load;
            else if (wdt_q != '0)    wdt_d = wdt_q - WDT_WIDTH'(1);
            if (wdt_fire) begin
               wdt_expired_d = 1'b1;
               state_d       = S_RST_PULSE;
               cnt_d         = '0;
            end else if (accept) begin
               case (req_type)
                  2'b00: begin
                     if (req_data[2]) begin
                        div_err_d = 1'b1;
                     end else begin
                        code_d  = req_data[2:0];
                        state_d = S_DIV_GATE;
                        cnt_d   = '0;
                     end
                  end
                  2'b01: begin
                     state_d = S_RST_PULSE;
                     cnt_d   = '0;
                  end
                  2'b10:   auto_en_d = req_data[0];
                  default: wdt_d     = wdt_load;
               endcase
            end
         end
         S_DIV_GATE: begin
            if (cnt_q == CNT_W'(DIV_GATE_CYCLES - 1)) begin
               state_d       = S_DIV_SWITCH;
               cnt_d         = '0;
               clk_div_sel_d = code_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DIV_SWITCH: begin
            state_d = S_DIV_SETTLE;
            cnt_d   = '0;
         end
         S_DIV_SETTLE: begin
            if (cnt_q == CNT_W'(DIV_SETTLE_CYCLES - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RST_PULSE: begin
            if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
               state_d = S_RST_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RST_WAIT: begin
            if (rst_done) begin
               state_d = S_IDLE;
               wdt_d   = wdt_load;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_DIV_GATE, S_DIV_SWITCH, S_DIV_SETTLE: clk_gate_en_d = 1'b1;
         S_IDLE:  clk_gate_en_d = auto_en_d && (idle_cnt_d == IDLE_W'(IDLE_GATE_CYCLES));
         default: clk_gate_en_d = 1'b0;
      endcase
      rst_ext_n_d = (state_d != S_RST_PULSE);
      busy_d      = (state_d != S_IDLE);
      req_ready_d = (state_d == S_IDLE) && !(wdt_en && (wdt_d == '0));
   end

   // State and output registers.
   always_ff @(posedge clk_ref or negedge por_n) begin
      if (!por_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         code_q        <= '0;
         clk_div_sel_q <= '0;
         clk_gate_en_q <= 1'b0;
         rst_ext_n_q   <= 1'b1;
         busy_q        <= 1'b0;
         wdt_expired_q <= 1'b0;
         div_err_q     <= 1'b0;
         req_ready_q   <= 1'b0;
         auto_en_q     <= 1'b0;
         wdt_q         <= wdt_load;
         idle_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         code_q        <= code_d;
         clk_div_sel_q <= clk_div_sel_d;
         clk_gate_en_q <= clk_gate_en_d;
         rst_ext_n_q   <= rst_ext_n_d;
         busy_q        <= busy_d;
         wdt_expired_q <= wdt_expired_d;
         div_err_q     <= div_err_d;
         req_ready_q   <= req_ready_d;
         auto_en_q     <= auto_en_d;
         wdt_q         <= wdt_d;
         idle_cnt_q    <= idle_cnt_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign clk_div_sel = clk_div_sel_q;
   assign clk_gate_en = clk_gate_en_q;
   assign rst_ext_n   = rst_ext_n_q;
   assign busy        = busy_q;
   assign wdt_expired = wdt_expired_q;
   assign div_err     = div_err_q;

endmodule

// File: tb/tb_clock_reset_controller.sv
// Scoreboard bench for clock_reset_controller with default parameters.
module tb_clock_reset_controller;

   localparam int unsigned W = 16;

   logic         clk_ref;
   logic         por_n;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_type;
   logic [W-1:0] req_data;
   logic         wdt_en;
   logic [W-1:0] wdt_load;
   logic         cpu_idle;
   logic         wake_req;
   logic         rst_done;
   logic [2:0]   clk_div_sel;
   logic         clk_gate_en;
   logic         rst_ext_n;
   logic         busy;
   logic         wdt_expired;
   logic         div_err;

   clock_reset_controller dut (
      .clk_ref     (clk_ref),
      .por_n       (por_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_type    (req_type),
      .req_data    (req_data),
      .wdt_en      (wdt_en),
      .wdt_load    (wdt_load),
      .cpu_idle    (cpu_idle),
      .wake_req    (wake_req),
      .rst_done    (rst_done),
      .clk_div_sel (clk_div_sel),
      .clk_gate_en (clk_gate_en),
      .rst_ext_n   (rst_ext_n),
      .busy        (busy),
      .wdt_expired (wdt_expired),
      .div_err     (div_err)
   );

   // Reference clock.
   initial begin
      clk_ref = 1'b0;
      forever #5 clk_ref = ~clk_ref;
   end

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         it = sb_q.pop_front();
         check_eq(it.tag, obs, it.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_ref);
      #1;
   endtask

   task automatic send(input logic [1:0] t, input logic [W-1:0] d);
      req_valid = 1'b1;
      req_type  = t;
      req_data  = d;
      tick();
      req_valid = 1'b0;
   endtask

   // Reset values of every output.
   task automatic expect_reset_outputs(input string pfx);
      sb_push({pfx, "_sel"}, 0);
      sb_push({pfx, "_gate"}, 0);
      sb_push({pfx, "_rst_n"}, 1);
      sb_push({pfx, "_busy"}, 0);
      sb_push({pfx, "_expired"}, 0);
      sb_push({pfx, "_div_err"}, 0);
      sb_push({pfx, "_ready"}, 0);
      sb_check(32'(clk_div_sel));
      sb_check(32'(clk_gate_en));
      sb_check(32'(rst_ext_n));
      sb_check(32'(busy));
      sb_check(32'(wdt_expired));
      sb_check(32'(div_err));
      sb_check(32'(req_ready));
   endtask

   initial begin
      int n_busy, pre, post, mis, low, gated, wcnt, n;
      logic seen;

      por_n = 1'b0; req_valid = 1'b0; req_type = '0; req_data = '0;
      wdt_en = 1'b0; wdt_load = 16'd1000; cpu_idle = 1'b0; wake_req = 1'b0; rst_done = 1'b0;
      repeat (3) tick();
      expect_reset_outputs("por");
      por_n = 1'b1;
      tick();
      sb_push("ready_after_release", 1);
      sb_check(32'(req_ready));

      // Illegal divider code
      sb_push("bad_div_err", 1);
      sb_push("bad_div_sel", 0);
      sb_push("bad_div_busy", 0);
      sb_push("bad_div_ready", 1);
      sb_push("bad_div_err_clear", 0);
      send(2'b00, 16'h0005);
      sb_check(32'(div_err));
      sb_check(32'(clk_div_sel));
      sb_check(32'(busy));
      sb_check(32'(req_ready));
      tick();
      sb_check(32'(div_err));

      // Legal divider change to 3'b010
      sb_push("div_gate_pre_sel", 2);
      sb_push("div_gate_post_sel", 17);
      sb_push("div_busy_cycles", 19);
      sb_push("div_gate_vs_busy", 0);
      sb_push("div_sel_final", 2);
      sb_push("div_gate_after", 0);
      sb_push("div_ready_after", 1);
      send(2'b00, 16'h0002);
      n_busy = 0; pre = 0; post = 0; mis = 0;
      for (int i = 0; i < 100 && busy; i++) begin
         n_busy++;
         if (clk_gate_en && clk_div_sel == 3'd0) pre++;
         if (clk_gate_en && clk_div_sel == 3'd2) post++;
         if (clk_gate_en != busy) mis++;
         tick();
      end
      sb_check(32'(pre));
      sb_check(32'(post));
      sb_check(32'(n_busy));
      sb_check(32'(mis));
      sb_check(32'(clk_div_sel));
      sb_check(32'(clk_gate_en));
      sb_check(32'(req_ready));

      // Software reset; rst_done returns ten cycles after the pulse
      sb_push("rst_low_cycles", 32);
      sb_push("rst_gate_during", 0);
      sb_push("rst_wait_busy", 11);
      sb_push("rst_busy_after", 0);
      sb_push("rst_ready_after", 1);
      sb_push("rst_sel_kept", 2);
      send(2'b01, 16'h0000);
      low = 0; gated = 0;
      for (int i = 0; i < 200 && rst_ext_n == 1'b0; i++) begin
         low++;
         gated += int'(clk_gate_en);
         tick();
      end
      wcnt = 0;
      repeat (10) begin
         wcnt += int'(busy);
         tick();
      end
      rst_done = 1'b1;
      wcnt += int'(busy);
      tick();
      rst_done = 1'b0;
      sb_check(32'(low));
      sb_check(32'(gated));
      sb_check(32'(wcnt));
      sb_check(32'(busy));
      sb_check(32'(req_ready));
      sb_check(32'(clk_div_sel));

      // Auto-gate enable and 64-cycle idle threshold
      sb_push("ag_busy", 0);
      sb_push("ag_ready", 1);
      sb_push("ag_rise_cycles", 64);
      sb_push("ag_wake_clear", 0);
      sb_push("ag_63_no_gate", 0);
      sb_push("ag_pre_disable", 1);
      sb_push("ag_disable_clear", 0);
      send(2'b10, 16'h0001);
      sb_check(32'(busy));
      sb_check(32'(req_ready));
      cpu_idle = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if (clk_gate_en) break;
      end
      sb_check(32'(n));
      wake_req = 1'b1;
      tick();
      wake_req = 1'b0;
      sb_check(32'(clk_gate_en));
      cpu_idle = 1'b0;
      tick();
      cpu_idle = 1'b1;
      seen = 1'b0;
      repeat (63) begin
         tick();
         seen |= clk_gate_en;
      end
      cpu_idle = 1'b0;
      repeat (3) begin
         tick();
         seen |= clk_gate_en;
      end
      sb_check(32'(seen));
      cpu_idle = 1'b1;
      repeat (64) tick();
      sb_check(32'(clk_gate_en));
      send(2'b10, 16'h0000);
      sb_check(32'(clk_gate_en));
      cpu_idle = 1'b0;

      // Watchdog: kick on the cycle the counter would reach 0, then let it expire
      wdt_load = 16'd20;
      tick();
      wdt_en = 1'b1;
      repeat (19) tick();
      sb_push("wdt_pre_kick_rst_n", 1);
      sb_push("wdt_pre_kick_ready", 1);
      sb_push("wdt_kick_to_expiry", 21);
      sb_push("wdt_expired_set", 1);
      sb_push("wdt_busy", 1);
      sb_push("wdt_gate", 0);
      sb_check(32'(rst_ext_n));
      sb_check(32'(req_ready));
      send(2'b11, 16'h0000);
      // Reloaded to 20: reaches 0 after 20 edges, expiry registers on the 21st.
      n = 0;
      while (rst_ext_n && n < 100) begin
         tick();
         n++;
      end
      sb_check(32'(n));
      sb_check(32'(wdt_expired));
      sb_check(32'(busy));
      sb_check(32'(clk_gate_en));

      // Power-on reset in the middle of the reset pulse
      repeat (5) tick();
      por_n = 1'b0;
      #1;
      expect_reset_outputs("por_in_rst_pulse");
      wdt_en = 1'b0;
      tick();
      por_n = 1'b1;
      tick();

      // Power-on reset during divider settle
      sb_push("settle_gate", 1);
      sb_push("settle_sel", 3);
      send(2'b00, 16'h0003);
      repeat (5) tick();
      sb_check(32'(clk_gate_en));
      sb_check(32'(clk_div_sel));
      por_n = 1'b0;
      #1;
      expect_reset_outputs("por_in_div_settle");
      tick();
      por_n = 1'b1;
      tick();

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
